// File: rtl/asm_endereco_atual_if.sv
// Player-control / address bus between the button front end and the address generator.
// The master drives the button levels and play enable; the slave returns the current address.
interface asm_endereco_atual_if #(
    parameter int ADDR_W = 22
);
    logic              passa_10s;
    logic              volta_10s;
    logic              count;
    logic [ADDR_W-1:0] endereco;

    modport master (
        output passa_10s,
        output volta_10s,
        output count,
        input  endereco
    );

    modport slave (
        input  passa_10s,
        input  volta_10s,
        input  count,
        output endereco
    );
endinterface

// File: rtl/asm_endereco_atual.sv
// Current-address generator for the sample memory: +1 per clock during playback, +/-10 s jumps.
// Define ASM_ENDERECO_WRAP_EN to wrap at the end of memory instead of saturating.
module asm_endereco_atual #(
    parameter int          ADDR_W   = 22,
    parameter int unsigned STEP_10S = 80000,
    parameter int unsigned MAX_ADDR = 4194303
) (
    input  logic                 clk,
    input  logic                 reset,
    asm_endereco_atual_if.slave  bus
);

    localparam logic [ADDR_W-1:0] STEP_A   = ADDR_W'(STEP_10S);
    localparam logic [ADDR_W-1:0] MAX_A    = ADDR_W'(MAX_ADDR);
    localparam logic [ADDR_W:0]   STEP_EXT = (ADDR_W+1)'(STEP_10S);
    localparam logic [ADDR_W:0]   MAX_EXT  = (ADDR_W+1)'(MAX_ADDR);

    typedef enum logic [2:0] {
        PARADO,
        CONTA,
        AVANCA,
        RETROCEDE,
        ESPERA
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] endereco_q;
    logic              press_fwd;
    logic              press_back;
    logic              any_button;

    // The sum is formed one bit wider so a carry out of ADDR_W is visible to the clamp.
    function automatic logic [ADDR_W-1:0] jump_fwd(input logic [ADDR_W-1:0] a);
        logic [ADDR_W:0] sum;
        sum = {1'b0, a} + STEP_EXT;
`ifdef ASM_ENDERECO_WRAP_EN
        return sum[ADDR_W-1:0];
`else
        return (sum > MAX_EXT) ? MAX_A : sum[ADDR_W-1:0];
`endif
    endfunction

    function automatic logic [ADDR_W-1:0] jump_back(input logic [ADDR_W-1:0] a);
        return (a >= STEP_A) ? (a - STEP_A) : '0;
    endfunction

    function automatic logic [ADDR_W-1:0] incr(input logic [ADDR_W-1:0] a);
`ifdef ASM_ENDERECO_WRAP_EN
        return (a == MAX_A) ? '0 : (a + ADDR_W'(1));
`else
        return (a == MAX_A) ? MAX_A : (a + ADDR_W'(1));
`endif
    endfunction

    // Both buttons together count as no press.
    assign press_fwd  = bus.passa_10s & ~bus.volta_10s;
    assign press_back = bus.volta_10s & ~bus.passa_10s;
    assign any_button = bus.passa_10s | bus.volta_10s;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= PARADO;
            endereco_q <= '0;
        end else begin
            case (state)
                PARADO, CONTA: begin
                    if (state == CONTA && bus.count) begin
                        endereco_q <= incr(endereco_q);
                    end
                    if (press_fwd) begin
                        state <= AVANCA;
                    end else if (press_back) begin
                        state <= RETROCEDE;
                    end else begin
                        state <= bus.count ? CONTA : PARADO;
                    end
                end
                AVANCA: begin
                    endereco_q <= jump_fwd(endereco_q);
                    state      <= ESPERA;
                end
                RETROCEDE: begin
                    endereco_q <= jump_back(endereco_q);
                    state      <= ESPERA;
                end
                // Holding a button parks here, so one press yields exactly one jump.
                ESPERA: begin
                    if (bus.count) begin
                        endereco_q <= incr(endereco_q);
                    end
                    if (any_button) begin
                        state <= ESPERA;
                    end else begin
                        state <= bus.count ? CONTA : PARADO;
                    end
                end
                default: begin
                    state <= PARADO;
                end
            endcase
        end
    end

    assign bus.endereco = endereco_q;

endmodule

// File: tb/tb_asm_endereco_atual.sv
// Directed bench for asm_endereco_atual: vector table plus reset and end-of-memory sequences.
module tb_asm_endereco_atual;

    localparam int          ADDR_W = 22;
    localparam logic [21:0] MAXV   = 22'd4194303;

`ifdef ASM_ENDERECO_WRAP_EN
    localparam logic [21:0] EXP_O4 = 22'd2;
    localparam logic [21:0] EXP_O7 = 22'd4;
    localparam logic [21:0] EXP_O8 = 22'd80004;
`else
    localparam logic [21:0] EXP_O4 = 22'd4194303;
    localparam logic [21:0] EXP_O7 = 22'd4114307;
    localparam logic [21:0] EXP_O8 = 22'd4194303;
`endif

    typedef struct {
        logic        p;
        logic        v;
        logic        c;
        int          n;
        logic [21:0] exp_addr;
    } vec_t;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;
    vec_t tbl[20];

    asm_endereco_atual_if #(.ADDR_W(ADDR_W)) ifc ();

    asm_endereco_atual dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [21:0] act, input logic [21:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: endereco=%0d required=%0d", name, act, exp_v);
        end
    endtask

    task automatic run(input logic p, input logic v, input logic c, input int n);
        ifc.passa_10s = p;
        ifc.volta_10s = v;
        ifc.count     = c;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        ifc.passa_10s = 1'b0;
        ifc.volta_10s = 1'b0;
        ifc.count     = 1'b0;
        reset         = 1'b0;

        //             p     v     c     n    expected
        tbl[0]  = '{1'b0, 1'b0, 1'b1, 100, 22'd99};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 10,  22'd80108};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 5,   22'd80113};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 10,  22'd122};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 50,  22'd122};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 10,  22'd131};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 5,   22'd136};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 3,   22'd136};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 3,   22'd136};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 3,   22'd0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 2,   22'd0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 4,   22'd0};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 10,  22'd10};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 3,   22'd0};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 1,   22'd0};
        tbl[15] = '{1'b1, 1'b0, 1'b1, 1,   22'd0};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 1,   22'd80000};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 1,   22'd80000};
        tbl[18] = '{1'b0, 1'b1, 1'b0, 2,   22'd0};
        tbl[19] = '{1'b0, 1'b0, 1'b0, 1,   22'd0};

        #12;
        check("reset_state", ifc.endereco, 22'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 20; i++) begin
            run(tbl[i].p, tbl[i].v, tbl[i].c, tbl[i].n);
            check($sformatf("vec%0d", i), ifc.endereco, tbl[i].exp_addr);
        end

        // Asynchronous reset in the middle of counting.
        run(1'b0, 1'b0, 1'b1, 20);
        check("pre_reset_count", ifc.endereco, 22'd19);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset", ifc.endereco, 22'd0);
        @(negedge clk);
        reset = 1'b1;
        check("reset_hold", ifc.endereco, 22'd0);
        run(1'b0, 1'b0, 1'b1, 3);
        check("post_reset_state", ifc.endereco, 22'd2);
        run(1'b0, 1'b0, 1'b0, 1);
        run(1'b0, 1'b1, 1'b0, 2);
        run(1'b0, 1'b0, 1'b0, 1);
        check("back_to_zero", ifc.endereco, 22'd0);

        // Walk up to the end of memory with paused forward jumps, then count the rest.
        for (int j = 0; j < 52; j++) begin
            run(1'b1, 1'b0, 1'b0, 2);
            run(1'b0, 1'b0, 1'b0, 1);
        end
        check("jumps_52", ifc.endereco, 22'd4160000);
        run(1'b0, 1'b0, 1'b1, 34299);
        check("near_end", ifc.endereco, MAXV - 22'd5);
        run(1'b0, 1'b0, 1'b1, 5);
        check("reach_max", ifc.endereco, MAXV);
        run(1'b0, 1'b0, 1'b1, 3);
        check("count_past_max", ifc.endereco, EXP_O4);
        run(1'b0, 1'b0, 1'b0, 1);
        run(1'b0, 1'b1, 1'b0, 2);
        run(1'b0, 1'b0, 1'b1, 4);
        check("back_from_end", ifc.endereco, EXP_O7);
        run(1'b1, 1'b0, 1'b0, 2);
        check("fwd_clamp", ifc.endereco, EXP_O8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/asm_endereco_atual.md
Name: asm_endereco_atual

Overview:
- Current-address generator for the audio player's sample memory.
- Advances a 22-bit read address once per clock while playback is enabled.
- Jumps forward or back by 10 seconds' worth of samples on a button press; each press causes exactly one jump.
- Sits between the player control inputs (play, +10s, -10s) and the memory address bus.

Parameters:
- ADDR_W, 22: width of endereco.
- STEP_10S, 80000: address delta for one 10 s jump (10 s x 8 kHz).
- MAX_ADDR, 4194303: last valid address, 2^ADDR_W - 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- passa_10s  input  1  +10 s request, level from a button; may be held for many cycles.
- volta_10s  input  1  -10 s request, level from a button; may be held for many cycles.
- count  input  1  1 = playback, increment address; 0 = pause, hold address.
- endereco  output  ADDR_W  current memory address (registered).

Behaviour:
- Reset:
  - While reset=0, asynchronously: endereco=0, state=PARADO.
  - Releasing reset to 1 resumes normal operation on the next rising edge.
- States:
  - PARADO: idle.
  - CONTA: counting.
  - AVANCA: one-cycle forward jump.
  - RETROCEDE: one-cycle backward jump.
  - ESPERA: wait for both buttons to be released.
- Decision from PARADO or CONTA, evaluated each edge:
  - Exactly one of passa_10s / volta_10s is 1: go to AVANCA or RETROCEDE respectively.
  - Both buttons are 1: ignore them and treat as no press.
  - No press: go to CONTA if count=1, otherwise PARADO.
- Counting:
  - In CONTA and ESPERA with count=1, endereco increments by 1 per clock.
  - In PARADO, endereco holds.
- Jumps:
  - AVANCA: endereco <= min(endereco + STEP_10S, MAX_ADDR).
  - RETROCEDE: endereco <= endereco - STEP_10S if endereco >= STEP_10S, else 0. No underflow wrap.
  - The jump replaces the +1 increment in that cycle.
- Latency: a button first sampled high at edge k moves the state to AVANCA/RETROCEDE; endereco takes the jumped value at edge k+1.
- After AVANCA or RETROCEDE the next state is always ESPERA.
- ESPERA:
  - Stays in ESPERA while either button is 1; counting continues per count.
  - With both buttons 0, goes to CONTA or PARADO per count.
  - Holding a button therefore yields one jump only.
- End of memory: count=1 at endereco=MAX_ADDR holds at MAX_ADDR (end of track).
- Width rules:
  - Perform the addition at ADDR_W+1 bits before clamping.
  - All comparisons are unsigned.
- count changing mid-jump does not cancel the jump.

Optional Feature:
- Macro ASM_ENDERECO_WRAP_EN.
- When defined:
  - Counting from MAX_ADDR wraps to 0.
  - A forward jump past MAX_ADDR wraps modulo 2^ADDR_W.
  - The backward jump still saturates at 0.
- When undefined: the saturating behaviour above applies.

Test Plan:
- Reset then count, 10 ns clock: reset=0 for 20 ns then 1, count=1 for 100 cycles -> endereco rises by 1 per clock, reaching 100 (+/-1 for release alignment).
- Forward jump: at endereco=A, pulse passa_10s high for 10 cycles -> endereco = A+80000 (plus the counts accrued in that window); single jump only, no repeat while held.
- Backward jump: at endereco=B >= 80000, pulse volta_10s for 10 cycles -> endereco = B-80000 plus the intervening counts; single jump.
- Pause and reset:
  - count=0 for 50 cycles -> endereco constant.
  - count=1 -> counting resumes from the held value.
  - reset=0 mid-count -> endereco=0 immediately, without waiting for a clock edge.
- Underflow and both buttons:
  - With count=0 and endereco=0, pulse volta_10s -> endereco stays 0.
  - At endereco=10, pulse volta_10s -> 0.
  - Assert passa_10s and volta_10s together -> no jump.
- Overflow: preload near end via a forward jump with endereco=MAX_ADDR-5, pulse passa_10s -> 4194303.
  - Without the macro, count holds at 4194303.
  - With ASM_ENDERECO_WRAP_EN, it rolls to 0.
